mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-ported, fixed-latency SRAM between the instruction-fetch stage and the memory stage of the 5-stage MIPS pipeline. Grants one access at a time, drives the SRAM command for a configurable number of wait cycles, and returns read data with a one-cycle ready pulse. Generates the freeze/stall qualifiers the hazard logic uses to hold the pipeline while an access is outstanding.

## Interface
- ADDR_W, 18, SRAM word-address width
- DATA_W, 32, data width
- WAIT_CYCLES, 4, SRAM access cycles per transfer (≥1)

- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  instruction fetch request
- if_addr  in  32  fetch byte address
- if_rdata  out  DATA_W  fetched instruction
- if_ready  out  1  fetch complete, one-cycle pulse
- mem_rd  in  1  data read request
- mem_wr  in  1  data write request
- mem_addr  in  32  data byte address
- mem_wdata  in  DATA_W  write data
- mem_rdata  out  DATA_W  read data
- mem_ready  out  1  data access complete, one-cycle pulse
- pipe_freeze  out  1  (mem_rd|mem_wr) & ~mem_ready
- if_stall  out  1  if_req & ~if_ready
- sram_addr  out  ADDR_W  word address = addr[ADDR_W+1:2]
- sram_wdata  out  DATA_W  write data to SRAM
- sram_we  out  1  write enable, held for whole access
- sram_oe  out  1  read enable, held for whole access
- sram_rdata  in  DATA_W  SRAM read data, valid in last access cycle

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: if mem_rd|mem_wr → latch owner=MEM, op, address, wdata; else if if_req → owner=IF, op=read; go ACCESS, counter=0. No request → stay.
- Priority: MEM always beats IF (older instruction); IF waits in IDLE.
- mem_rd and mem_wr both high: write wins.
- ACCESS: sram_addr/wdata/we/oe driven from latched values; counter increments; at counter==WAIT_CYCLES-1 capture sram_rdata into owner's rdata register, go DONE.
- DONE: assert owner's ready for exactly one cycle; sram_we/oe low; go IDLE.
- Once granted, access runs to completion even if the request drops (branch flush); ready still pulses, requester ignores it.
- Writes: mem_rdata not updated; mem_ready still pulses.
- Address bits [1:0] ignored; upper bits above ADDR_W+1 ignored.
- rdata registers hold last value until next completed read by same owner.

## Timing
- Request sampled in IDLE at cycle 0; ACCESS cycles 1..WAIT_CYCLES; ready high in cycle WAIT_CYCLES+1; earliest next grant sampled in WAIT_CYCLES+2. Latency WAIT_CYCLES+1, throughput one access per WAIT_CYCLES+2 cycles.
- Requester must hold request and address stable from assertion until ready.
- Reset (any time, incl. mid-access): state=IDLE, counter=0, sram_we=0, sram_oe=0, sram_addr=0, sram_wdata=0, if_ready=0, mem_ready=0, if_rdata=0, mem_rdata=0; aborted access produces no ready. pipe_freeze/if_stall follow inputs combinationally.
- All outputs except pipe_freeze/if_stall registered.

## Configuration
- MEM_ARB_STATS_EN defined: adds ports stat_freeze_cycles (out 32, cycles with pipe_freeze=1) and stat_if_grants (out 32, IF grants); both saturate at 32'hFFFF_FFFF, reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Package mem_arb_pkg: state enum (IDLE, ACCESS, DONE), owner enum (OWN_IF, OWN_MEM), default WAIT_CYCLES constant.
- One sub-module: mem_arb_wait_cnt (loadable up-counter with terminal-count flag).

## Test plan
- if_req, if_addr=32'h10, sram_rdata=32'hDEAD_BEEF → sram_addr=4, sram_oe high cycles 1–4, if_ready and if_rdata=DEADBEEF at cycle 5.
- if_req and mem_wr (addr 32'h400, wdata 32'h55) same cycle → MEM first: sram_we high cycles 1–4 at sram_addr=256, mem_ready cycle 5; IF granted cycle 6, if_ready cycle 11.
- mem_rd held → pipe_freeze=1 cycles 0–4, 0 at cycle 5 with mem_ready.
- if_req dropped at cycle 2 → access completes, if_ready pulses cycle 5, no further grant.
- rst asserted at cycle 3 of write → sram_we falls immediately, no mem_ready, next request restarts full latency.
- MEM_ARB_STATS_EN: three IF fetches and one 5-cycle freeze → stat_if_grants=3, stat_freeze_cycles=5.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and constants for the IF/MEM SRAM port arbiter.
// Revision : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    localparam int DEFAULT_WAIT_CYCLES = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } arb_owner_t;

    // A counter for a single-cycle access still needs one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_wait_cnt.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_wait_cnt
// Purpose  : Loadable up-counter with a terminal-count flag for access timing.
// Revision : 1.0  initial release
// ============================================================================
module mem_arb_wait_cnt #(
    parameter int WIDTH    = 2,
    parameter int TERMINAL = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

    assign tc = (count == WIDTH'(TERMINAL));

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one fixed-latency SRAM between instruction fetch and the
//            memory stage; MEM has priority. Optional counters via the
//            MEM_ARB_STATS_EN macro.
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [31:0]       mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              pipe_freeze,
    output logic              if_stall,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_we,
    output logic              sram_oe,
    input  logic [DATA_W-1:0] sram_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_freeze_cycles,
    output logic [31:0]       stat_if_grants
`endif
);

    localparam int CNT_W = cnt_width(WAIT_CYCLES);

    arb_state_t       r_state;
    arb_owner_t       r_owner;
    logic             r_wr;
    logic             w_mem_req;
    logic             w_cnt_tc;
    logic [CNT_W-1:0] w_cnt;
    logic             w_unused;

    assign w_mem_req   = mem_rd | mem_wr;
    assign pipe_freeze = w_mem_req & ~mem_ready;
    assign if_stall    = if_req & ~if_ready;

    // Byte-lane and out-of-range address bits are dropped deliberately.
    assign w_unused = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                        mem_addr[31:ADDR_W+2], mem_addr[1:0], w_cnt};

    mem_arb_wait_cnt #(
        .WIDTH    (CNT_W),
        .TERMINAL (WAIT_CYCLES - 1)
    ) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (r_state == IDLE),
        .en    (r_state == ACCESS),
        .count (w_cnt),
        .tc    (w_cnt_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_owner    <= OWN_IF;
            r_wr       <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_we    <= 1'b0;
            sram_oe    <= 1'b0;
            if_ready   <= 1'b0;
            mem_ready  <= 1'b0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
        end else begin
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_mem_req) begin
                        // Write wins when both strobes are raised.
                        r_owner    <= OWN_MEM;
                        r_wr       <= mem_wr;
                        sram_addr  <= mem_addr[ADDR_W+1:2];
                        sram_wdata <= mem_wdata;
                        sram_we    <= mem_wr;
                        sram_oe    <= ~mem_wr;
                        r_state    <= ACCESS;
                    end else if (if_req) begin
                        r_owner   <= OWN_IF;
                        r_wr      <= 1'b0;
                        sram_addr <= if_addr[ADDR_W+1:2];
                        sram_we   <= 1'b0;
                        sram_oe   <= 1'b1;
                        r_state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (w_cnt_tc) begin
                        if (!r_wr) begin
                            if (r_owner == OWN_MEM) begin
                                mem_rdata <= sram_rdata;
                            end else begin
                                if_rdata <= sram_rdata;
                            end
                        end
                        if_ready  <= (r_owner == OWN_IF);
                        mem_ready <= (r_owner == OWN_MEM);
                        sram_we   <= 1'b0;
                        sram_oe   <= 1'b0;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [31:0] r_freeze_cycles;
    logic [31:0] r_if_grants;
    logic        w_if_grant;

    assign w_if_grant = (r_state == IDLE) & ~w_mem_req & if_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_freeze_cycles <= '0;
            r_if_grants     <= '0;
        end else begin
            if (pipe_freeze && (r_freeze_cycles != 32'hFFFF_FFFF)) begin
                r_freeze_cycles <= r_freeze_cycles + 32'd1;
            end
            if (w_if_grant && (r_if_grants != 32'hFFFF_FFFF)) begin
                r_if_grants <= r_if_grants + 32'd1;
            end
        end
    end

    assign stat_freeze_cycles = r_freeze_cycles;
    assign stat_if_grants     = r_if_grants;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed and randomized checks of mem_port_arbiter against a
//            transaction-schedule reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW = 18;
    localparam int DW = 32;
    localparam int W  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [31:0]   if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          mem_rd = 1'b0;
    logic          mem_wr = 1'b0;
    logic [31:0]   mem_addr = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          pipe_freeze;
    logic          if_stall;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic          sram_we;
    logic          sram_oe;
    logic [DW-1:0] sram_rdata = '0;
`ifdef MEM_ARB_STATS_EN
    logic [31:0]   stat_freeze_cycles;
    logic [31:0]   stat_if_grants;
`endif

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_ready    (if_ready),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .pipe_freeze (pipe_freeze),
        .if_stall    (if_stall),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_we     (sram_we),
        .sram_oe     (sram_oe),
        .sram_rdata  (sram_rdata)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_freeze_cycles (stat_freeze_cycles),
        .stat_if_grants     (stat_if_grants)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: one granted transaction described by its grant cycle.
    int          m_gnt  = -1;
    int          m_free = 0;
    logic        m_mem  = 1'b0;
    logic        m_wr   = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wd   = '0;
    logic [31:0] m_cap  = '0;
    logic [31:0] exp_if_rd  = '0;
    logic [31:0] exp_mem_rd = '0;
    logic [31:0] m_frz = '0;
    logic [31:0] m_ifg = '0;
    logic        rd_fixed = 1'b0;

    logic        if_act = 1'b0;
    logic        mem_act = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic rdy_if();
        return (m_gnt >= 0) && (cyc == m_gnt + W + 1) && !m_mem;
    endfunction

    function automatic logic rdy_mem();
        return (m_gnt >= 0) && (cyc == m_gnt + W + 1) && m_mem;
    endfunction

    // Called at a falling edge with this cycle's inputs already driven.
    task automatic run_cycle();
        logic e_acc, e_ifr, e_mr, e_frz;
        #1;
        e_acc = (m_gnt >= 0) && (cyc > m_gnt) && (cyc <= m_gnt + W);
        e_ifr = rdy_if();
        e_mr  = rdy_mem();
        if (e_ifr && !m_wr) exp_if_rd = m_cap;
        if (e_mr && !m_wr)  exp_mem_rd = m_cap;
        e_frz = (mem_rd | mem_wr) & ~e_mr;

        check_val("if_ready",    {31'd0, if_ready},    {31'd0, e_ifr});
        check_val("mem_ready",   {31'd0, mem_ready},   {31'd0, e_mr});
        check_val("sram_oe",     {31'd0, sram_oe},     {31'd0, e_acc & ~m_wr});
        check_val("sram_we",     {31'd0, sram_we},     {31'd0, e_acc & m_wr});
        check_val("pipe_freeze", {31'd0, pipe_freeze}, {31'd0, e_frz});
        check_val("if_stall",    {31'd0, if_stall},    {31'd0, if_req & ~e_ifr});
        check_val("if_rdata",    if_rdata,  exp_if_rd);
        check_val("mem_rdata",   mem_rdata, exp_mem_rd);
        if (e_acc) begin
            check_val("sram_addr", {14'd0, sram_addr}, m_addr);
            if (m_wr) check_val("sram_wdata", sram_wdata, m_wd);
        end
`ifdef MEM_ARB_STATS_EN
        check_val("stat_freeze", stat_freeze_cycles, m_frz);
        check_val("stat_ifg",    stat_if_grants,     m_ifg);
        if (e_frz && m_frz != 32'hFFFF_FFFF) m_frz = m_frz + 1;
`endif

        if ((m_gnt >= 0) && (cyc == m_gnt + W)) m_cap = sram_rdata;
        if ((cyc >= m_free) && (mem_rd || mem_wr || if_req)) begin
            m_gnt  = cyc;
            m_mem  = mem_rd || mem_wr;
            m_wr   = m_mem && mem_wr;
            m_addr = ((m_mem ? mem_addr : if_addr) >> 2) & ((32'd1 << AW) - 1);
            m_wd   = mem_wdata;
            m_free = cyc + W + 2;
            if (!m_mem && m_ifg != 32'hFFFF_FFFF) m_ifg = m_ifg + 1;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Called at a falling edge; releases reset one cycle later.
    task automatic do_reset();
        rst = 1'b1;
        if_act = 1'b0; mem_act = 1'b0;
        if_req = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
        #1;
        check_val("rst_we",     {31'd0, sram_we},   32'd0);
        check_val("rst_oe",     {31'd0, sram_oe},   32'd0);
        check_val("rst_addr",   {14'd0, sram_addr}, 32'd0);
        check_val("rst_wdata",  sram_wdata,         32'd0);
        check_val("rst_if_rdy", {31'd0, if_ready},  32'd0);
        check_val("rst_mem_rdy",{31'd0, mem_ready}, 32'd0);
        check_val("rst_if_rd",  if_rdata,           32'd0);
        check_val("rst_mem_rd", mem_rdata,          32'd0);
        m_gnt = -1; exp_if_rd = '0; exp_mem_rd = '0; m_frz = '0; m_ifg = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc++;
        m_free = cyc;
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic mr,
                         input logic mw, input logic [31:0] ma, input logic [31:0] md, input int n);
        if_req = ir; if_addr = ia; mem_rd = mr; mem_wr = mw; mem_addr = ma; mem_wdata = md;
        for (int i = 0; i < n; i++) begin
            if (!rd_fixed) sram_rdata = $urandom;
            run_cycle();
        end
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Single fetch at byte address 0x10.
        rd_fixed = 1'b1; sram_rdata = 32'hDEAD_BEEF;
        drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 5);
        drive(1'b0, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 2);
        check_val("dir_if_rdata", if_rdata, 32'hDEAD_BEEF);
        rd_fixed = 1'b0;

        // Simultaneous fetch and write: MEM first, IF follows.
        drive(1'b1, 32'h20, 1'b0, 1'b1, 32'h400, 32'h55, 5);
        drive(1'b1, 32'h20, 1'b0, 1'b0, 32'h400, 32'h55, 6);
        drive(1'b0, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 2);

        // Held data read with freeze.
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'hFFFF_FF0C, 32'h0, 5);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2);

        // Fetch flushed after grant.
        drive(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 2);
        drive(1'b0, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 6);

        // Reset in the middle of a write, then a fresh read.
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h800, 32'hA5A5_0001, 3);
        do_reset();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h808, 32'h1234_5678, 5);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2);

        // Randomized traffic from both requesters.
        for (int t = 0; t < 4000; t++) begin
            if (rdy_if())  if_act = 1'b0;
            if (rdy_mem()) mem_act = 1'b0;
            if (if_act && $urandom_range(0, 31) == 0) if_act = 1'b0;
            if (!if_act && $urandom_range(0, 3) == 0) begin
                if_act = 1'b1;
                if_addr = $urandom;
            end
            if (!mem_act && $urandom_range(0, 5) == 0) begin
                int kind;
                kind = $urandom_range(0, 3);
                mem_act = 1'b1;
                mem_rd = (kind != 1);
                mem_wr = (kind == 1) || (kind == 2);
                mem_addr = $urandom;
                mem_wdata = $urandom;
            end
            if_req = if_act;
            if (!mem_act) begin
                mem_rd = 1'b0;
                mem_wr = 1'b0;
            end
            sram_rdata = $urandom;
            if ($urandom_range(0, 499) == 0) do_reset();
            else run_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
